// File: rtl/free_list.sv
// free_list: walks a linked card list in RAM, clearing each node and flagging unallocated revisits
module free_list (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  address,
  output logic        finished_freeing,
  output logic [9:0]  freed_count,
  output logic        free_error,
  output logic [9:0]  ram_address,
  output logic        ram_clock,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [9:0] next, next_n, addr_n, count_n;
  logic fin_n, err_n, wren_n;
  logic unused_bits;
  assign unused_bits = ^ram_q[30:10];
  assign ram_clock = clock;
  assign ram_data = '0;
  always_comb begin
    state_n = state;
    next_n = next;
    addr_n = ram_address;
    count_n = freed_count;
    fin_n = finished_freeing;
    err_n = free_error;
    wren_n = ram_wren;
    case (state)
      IDLE: if (enable) begin
        count_n = '0;
        err_n = 1'b0;
        if (address != '0) begin
          addr_n = address;
          fin_n = 1'b0;
          state_n = ADDR;
        end
      end
      ADDR: state_n = DATA;
      DATA: if (!ram_q[31]) begin
        err_n = 1'b1;
        state_n = DONE;
      end else begin
        next_n = ram_q[9:0];
        wren_n = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        wren_n = 1'b0;
        count_n = freed_count + 10'd1;
        addr_n = next == '0 ? ram_address : next;
        state_n = next == '0 ? DONE : ADDR;
      end
      DONE: begin
        fin_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      next <= '0;
      ram_address <= '0;
      freed_count <= '0;
      finished_freeing <= 1'b1;
      free_error <= 1'b0;
      ram_wren <= 1'b0;
    end else begin
      state <= state_n;
      next <= next_n;
      ram_address <= addr_n;
      freed_count <= count_n;
      finished_freeing <= fin_n;
      free_error <= err_n;
      ram_wren <= wren_n;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list against a behavioural 1024x32 RAM
module tb_free_list;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [9:0] address = '0;
  logic finished_freeing, free_error, ram_wren, ram_clock;
  logic [9:0] freed_count, ram_address;
  logic [31:0] ram_data, ram_q;
  logic [31:0] mem [0:1023];
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  free_list dut (
    .clock(clock), .reset(reset), .enable(enable), .address(address),
    .finished_freeing(finished_freeing), .freed_count(freed_count),
    .free_error(free_error), .ram_address(ram_address), .ram_clock(ram_clock),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] = ram_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (ram_wren) begin
      if (exp_q.size() == 0) check("wren_unexpected", {22'd0, ram_address}, 32'h3ff);
      else check("wren_addr", {22'd0, ram_address}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic start(input logic [9:0] head);
    @(negedge clock);
    enable = 1'b1;
    address = head;
    @(posedge clock);
    #1;
    enable = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int lat, input int cnt, input logic err);
    int n = 0;
    while (!finished_freeing && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_count"}, {22'd0, freed_count}, cnt);
    check({tag, "_error"}, {31'd0, free_error}, {31'd0, err});
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    repeat (2) @(posedge clock);
    #1;
    check("rst_fin", {31'd0, finished_freeing}, 1);
    check("rst_count", {22'd0, freed_count}, 0);
    check("rst_err", {31'd0, free_error}, 0);
    check("rst_wren", {31'd0, ram_wren}, 0);
    check("rst_addr", {22'd0, ram_address}, 0);
    @(negedge clock);
    reset = 1'b0;

    mem[32] = 32'h8000_2C00;
    exp_q.push_back(10'd32);
    start(10'd32);
    check("single_busy", {31'd0, finished_freeing}, 0);
    finish_op("single", 4, 1, 1'b0);
    check("single_mem", mem[32], 0);

    mem[64] = 32'h8000_4460;
    mem[96] = 32'h8000_8880;
    mem[128] = 32'h8000_C400;
    exp_q.push_back(10'd64);
    exp_q.push_back(10'd96);
    exp_q.push_back(10'd128);
    start(10'd64);
    finish_op("three", 10, 3, 1'b0);
    check("three_mem64", mem[64], 0);
    check("three_mem96", mem[96], 0);
    check("three_mem128", mem[128], 0);

    mem[64] = 32'h8000_0460;
    mem[96] = 32'h8000_0840;
    exp_q.push_back(10'd64);
    exp_q.push_back(10'd96);
    start(10'd64);
    finish_op("cycle", 9, 2, 1'b1);
    check("cycle_mem64", mem[64], 0);
    check("cycle_mem96", mem[96], 0);

    start(10'd0);
    for (int i = 0; i < 4; i++) begin
      check("null_fin", {31'd0, finished_freeing}, 1);
      @(posedge clock);
      #1;
    end
    check("null_count", {22'd0, freed_count}, 0);
    check("null_err", {31'd0, free_error}, 0);
    check("null_sb_empty", exp_q.size(), 0);

    mem[200] = 32'h8000_00C9;
    mem[201] = 32'h8000_00CA;
    mem[202] = 32'h8000_00CB;
    mem[203] = 32'h8000_00CC;
    mem[204] = 32'h8000_0000;
    exp_q.push_back(10'd200);
    start(10'd200);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_fin", {31'd0, finished_freeing}, 1);
    check("midrst_count", {22'd0, freed_count}, 0);
    check("midrst_err", {31'd0, free_error}, 0);
    check("midrst_wren", {31'd0, ram_wren}, 0);
    check("midrst_addr", {22'd0, ram_address}, 0);
    check("midrst_sb_empty", exp_q.size(), 0);
    @(negedge clock);
    reset = 1'b0;
    check("midrst_mem200", mem[200], 0);
    check("midrst_mem201", mem[201], 32'h8000_00CA);
    check("midrst_mem204", mem[204], 32'h8000_0000);

    for (int a = 201; a <= 204; a++) exp_q.push_back(a[9:0]);
    start(10'd201);
    finish_op("resume", 13, 4, 1'b0);
    check("resume_mem202", mem[202], 0);
    check("resume_mem204", mem[204], 0);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
